// File: rtl/hs32_fetchq.sv
// hs32_fetchq -- instruction prefetch queue between the memory port and hs32_decode.
//
// Issues sequential 32-bit reads ahead of decode and buffers up to DEPTH words
// together with the PC each word was fetched from. Decode sees the head entry
// on a req/rdy handshake. Exec redirects the fetch stream with flush/newpc.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   flush  in   redirect strobe from exec (one cycle)
//   newpc  in   redirect target, sampled when flush=1
//   addr   out  memory read address, held stable while reqm=1
//   reqm   out  memory read request (at most one read outstanding)
//   rdym   in   memory done; dtrm valid this cycle
//   dtrm   in   memory read data
//   instd  out  head instruction to decode
//   pcd    out  PC of instd
//   reqd   out  head valid (queue non-empty)
//   rdyd   in   decode accepts head
//   level  out  current occupancy
module hs32_fetchq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [31:0]              newpc,
  output logic [31:0]              addr,
  output logic                     reqm,
  input  logic                     rdym,
  input  logic [31:0]              dtrm,
  output logic [31:0]              instd,
  output logic [31:0]              pcd,
  output logic                     reqd,
  input  logic                     rdyd,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTHV = (PW+1)'(DEPTH);

  logic [31:0]   meminst [DEPTH];
  logic [31:0]   mempc   [DEPTH];
  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic [31:0]   fetchpc;
  logic          discard;

  logic          land;
  logic          push;
  logic          pop;
  logic [PW:0]   levelnext;
  logic          canissue;

  // A read is in flight exactly while reqm is high, because the request is
  // held until rdym. A landing word is only kept if no flush has happened
  // since its request was issued (discard). The slot for the next read is
  // reserved at issue, so a new request only goes out if the occupancy after
  // this edge still leaves room for it.
  always_comb begin
    land      = reqm && rdym;
    push      = land && !discard;
    pop       = reqd && rdyd;
    levelnext = level;
    if (push && !pop) begin
      levelnext = level + 1'b1;
    end else if (pop && !push) begin
      levelnext = level - 1'b1;
    end
    canissue  = (!reqm || rdym) && (levelnext < DEPTHV);
  end

  // Main state. Flush wins over everything: the queue empties, any pop in
  // the same cycle is void, and the fetch stream restarts at newpc. A read
  // still pending on the bus must stay on the bus, so it is marked for
  // discard and the redirected request waits for it to complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr    <= RESET_PC;
      fetchpc <= RESET_PC;
      reqm    <= 1'b0;
      discard <= 1'b0;
      wrptr   <= '0;
      rdptr   <= '0;
      level   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        meminst[i] <= '0;
        mempc[i]   <= '0;
      end
    end else if (flush) begin
      level <= '0;
      wrptr <= '0;
      rdptr <= '0;
      if (reqm && !rdym) begin
        discard <= 1'b1;
        fetchpc <= newpc;
      end else begin
        discard <= 1'b0;
        reqm    <= 1'b1;
        addr    <= newpc;
        fetchpc <= newpc + STEP;
      end
    end else begin
      if (push) begin
        meminst[wrptr] <= dtrm;
        mempc[wrptr]   <= addr;
        wrptr          <= wrptr + 1'b1;
      end
      if (pop) begin
        rdptr <= rdptr + 1'b1;
      end
      level <= levelnext;
      if (land) begin
        discard <= 1'b0;
      end
      if (canissue) begin
        reqm    <= 1'b1;
        addr    <= fetchpc;
        fetchpc <= fetchpc + STEP;
      end else if (land) begin
        reqm <= 1'b0;
      end
    end
  end

  // Head entry is read straight out of the registered storage; there is no
  // path from dtrm to instd, so an empty queue never forwards memory data.
  always_comb begin
    reqd  = (level != '0);
    instd = meminst[rdptr];
    pcd   = mempc[rdptr];
  end

endmodule

// File: tb/tb_hs32_fetchq.sv
// tb_hs32_fetchq -- self-checking bench for hs32_fetchq.
//
// A behavioural memory answers reads after a random delay with data that is a
// fixed function of the address. The reference model is a queue of {pc,inst}
// words plus the expected next fetch address; a flush empties it and marks a
// still-pending read as stale so its data is never expected.
module tb_hs32_fetchq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] STEP     = 32'd4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] newpc;
  logic [31:0] addr;
  logic        reqm;
  logic        rdym;
  logic [31:0] dtrm;
  logic [31:0] instd;
  logic [31:0] pcd;
  logic        reqd;
  logic        rdyd;
  logic [2:0]  level;

  int vectors;
  int miscompares;

  logic [63:0] mq[$];
  logic [31:0] expfetch;
  logic [31:0] reqaddr;
  bit          stale;
  bit          held;
  bit          expreqm;

  hs32_fetchq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .newpc(newpc),
    .addr(addr), .reqm(reqm), .rdym(rdym), .dtrm(dtrm),
    .instd(instd), .pcd(pcd), .reqd(reqd), .rdyd(rdyd), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    expfetch = RESET_PC;
    reqaddr  = RESET_PC;
    stale    = 1'b0;
    held     = 1'b0;
    expreqm  = 1'b0;
  endtask

  // Called at a negedge: check the state left by the last edge, drive the
  // inputs for the coming edge, advance the model, then move to the next negedge.
  task automatic applyStimulus(input bit fl, input logic [31:0] npc, input int pm, input int pd);
    bit land;
    bit popv;
    checkOutput("reqd", 32'(reqd), (mq.size() != 0) ? 32'd1 : 32'd0);
    checkOutput("level", 32'(level), 32'(mq.size()));
    if (mq.size() != 0) begin
      checkOutput("pcd", pcd, mq[0][63:32]);
      checkOutput("instd", instd, mq[0][31:0]);
    end
    checkOutput("reqm", 32'(reqm), 32'(expreqm));
    if (reqm && expreqm) begin
      if (held) begin
        checkOutput("addr_hold", addr, reqaddr);
      end else begin
        checkOutput("addr_issue", addr, expfetch);
        reqaddr  = expfetch;
        expfetch = expfetch + STEP;
      end
    end

    flush = fl;
    newpc = npc;
    rdym  = reqm && ($urandom_range(1, 100) <= pm);
    dtrm  = rdym ? memfn(addr) : $urandom();
    rdyd  = ($urandom_range(1, 100) <= pd);

    land = rdym;
    popv = (mq.size() != 0) && rdyd;
    if (fl) begin
      mq.delete();
      expfetch = npc;
      stale    = expreqm && !land;
      held     = expreqm && !land;
      expreqm  = 1'b1;
    end else begin
      if (popv) void'(mq.pop_front());
      if (land) begin
        if (!stale) mq.push_back({reqaddr, memfn(reqaddr)});
        stale = 1'b0;
      end
      held    = expreqm && !land;
      expreqm = held || (mq.size() < DEPTH);
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    flush = 1'b0;
    newpc = '0;
    rdym  = 1'b0;
    dtrm  = '0;
    rdyd  = 1'b0;
  endtask

  // Reset held across two edges, reset state checked, released at a negedge.
  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    modelReset();
    checkOutput("rst_reqm", 32'(reqm), 32'd0);
    checkOutput("rst_addr", addr, RESET_PC);
    checkOutput("rst_reqd", 32'(reqd), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_pcd", pcd, 32'd0);
    checkOutput("rst_instd", instd, 32'd0);
    reset = 1'b1;
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic asyncReset();
    idleInputs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_reqm", 32'(reqm), 32'd0);
    checkOutput("arst_reqd", 32'(reqd), 32'd0);
    checkOutput("arst_level", 32'(level), 32'd0);
    @(negedge clk);
    modelReset();
    checkOutput("arst_addr", addr, RESET_PC);
    reset = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idleInputs();
    reset = 1'b0;
    modelReset();
    @(negedge clk);

    // Streaming: memory answers every cycle, decode always ready.
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 100, 100);

    // Back-pressure: decode stalled until the queue fills, then released.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 100, 0);
    checkOutput("full_level", 32'(level), 32'd4);
    checkOutput("full_reqm", 32'(reqm), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 100, 100);

    // Flush while a read is in flight, memory slow to answer.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 100, 100);
    applyStimulus(1'b1, 32'h0000_1000, 0, 100);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 0, 100);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 100, 100);

    // Flush in the same cycle as a landing read and a pop, with two queued.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 100, 0);
    checkOutput("pre_flush_level", 32'(level), 32'd2);
    applyStimulus(1'b1, 32'h0000_2000, 100, 100);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 100, 100);

    // Fetch address wrap through 2^32.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 100, 100);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 100, 100);

    // Async reset with three queued and a request outstanding.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 100, 0);
    checkOutput("pre_arst_level", 32'(level), 32'd3);
    checkOutput("pre_arst_reqm", 32'(reqm), 32'd1);
    asyncReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 100, 100);

    // Randomised traffic with occasional redirects, some near the wrap point.
    for (int blk = 0; blk < 10; blk++) begin
      int pm;
      int pd;
      pm = $urandom_range(20, 100);
      pd = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        bit fl;
        logic [31:0] npc;
        fl  = ($urandom_range(1, 100) <= 4);
        npc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
        applyStimulus(fl, npc, pm, pd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
